// File: rtl/led_index_sequencer.sv
// Running-light index generator feeding a 3-to-8 one-hot decoder.
// A debounced push key toggles between RUN and PAUSE; a prescaler sets the step rate.
module led_index_sequencer #(
    parameter int CNT_MAX = 24_999_999,
    parameter int DEB_MAX = 999_999
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    input  logic dir,
    output logic in_1,
    output logic in_2,
    output logic in_3,
    output logic step_tick,
    output logic running
);

    localparam int PRE_W = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int DEB_W = (DEB_MAX > 0) ? $clog2(DEB_MAX + 1) : 1;
    localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(CNT_MAX);
    localparam logic [DEB_W-1:0] DEB_TOP = DEB_W'(DEB_MAX);

    typedef enum logic {
        PAUSE = 1'b0,
        RUN   = 1'b1
    } state_t;

    logic             key_m;
    logic             key_s;
    logic             key_stable;
    logic [DEB_W-1:0] deb_cnt;
    logic             key_flag;

    state_t           state;
    state_t           state_next;

    logic [PRE_W-1:0] pre_cnt;
    logic             step;
    logic [2:0]       idx;

    // Two-flop synchroniser; idle level is 1 since the key is active-low.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            key_m <= 1'b1;
            key_s <= 1'b1;
        end else begin
            key_m <= key_in;
            key_s <= key_m;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            key_stable <= 1'b1;
            deb_cnt    <= '0;
        end else if (key_s == key_stable) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_TOP) begin
            key_stable <= key_s;
            deb_cnt    <= '0;
        end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end

    // Pulses in the cycle whose edge commits a press; releases are ignored.
    assign key_flag = (key_s != key_stable) && (deb_cnt == DEB_TOP) && !key_s;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (key_flag) state_next = PAUSE;
            PAUSE:   if (key_flag) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        running = (state == RUN);
    end

    // The step uses the current state, so a press landing on terminal count
    // still advances once before pausing.
    assign step = (state == RUN) && (pre_cnt == PRE_TOP);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pre_cnt <= '0;
        end else if (state == RUN) begin
            pre_cnt <= step ? '0 : pre_cnt + PRE_W'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            idx       <= 3'd0;
            step_tick <= 1'b0;
        end else begin
            step_tick <= step;
            if (step) begin
                idx <= dir ? idx + 3'd1 : idx - 3'd1;
            end
        end
    end

    assign in_1 = idx[2];
    assign in_2 = idx[1];
    assign in_3 = idx[0];

endmodule
